// File: rtl/mult_norm_ctrl.sv
// mult_norm_ctrl: sequential normaliser for the FP multiplier raw product, valid/ready in and out
module mult_norm_ctrl #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W-1:0]        in_exp,
  input  logic [2*MANT_W+1:0]     in_mant,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W-1:0]        out_exp,
  output logic [2*MANT_W+1:0]     out_mant,
  output logic                    ovf,
  output logic                    unf,
  output logic                    zero,
  output logic                    busy
);
  localparam int PW = 2*MANT_W+2;
  localparam logic [EXP_W-1:0] EMAX = '1;

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t          state_q, state_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [PW-1:0]    mant_q, mant_d;
  logic             ovf_q, ovf_d, unf_q, unf_d, zero_q, zero_d;

  // next-state: accept in IDLE, one normalisation step per cycle in NORM, hold in DONE until taken
  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    mant_d  = mant_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = NORM;
        exp_d   = in_exp;
        mant_d  = in_mant;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        zero_d  = 1'b0;
      end
      NORM: begin
        if (mant_q[PW-1]) begin
          mant_d  = mant_q >> 1;
          exp_d   = (exp_q == EMAX) ? exp_q : exp_q + 1'b1;
          ovf_d   = (exp_q == EMAX) || (exp_q == EMAX - 1'b1);
          state_d = DONE;
        end else if (mant_q == '0) begin
          exp_d   = '0;
          zero_d  = 1'b1;
          state_d = DONE;
        end else if (mant_q[PW-2]) begin
          state_d = DONE;
        end else if (exp_q == '0) begin
          unf_d   = 1'b1;
          state_d = DONE;
        end else begin
          mant_d  = mant_q << 1;
          exp_d   = exp_q - 1'b1;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers; async reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      exp_q   <= '0;
      mant_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      mant_q  <= mant_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign out_exp   = exp_q;
  assign out_mant  = mant_q;
  assign ovf       = ovf_q & out_valid;
  assign unf       = unf_q & out_valid;
  assign zero      = zero_q & out_valid;
endmodule

// File: tb/tb_mult_norm_ctrl.sv
// tb_mult_norm_ctrl: directed vectors with a scoreboard queue and an independent output monitor
module tb_mult_norm_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_exp = '0;
  logic [47:0] in_mant = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_exp;
  logic [47:0] out_mant;
  logic        ovf, unf, zero, busy;

  typedef struct {
    logic [7:0]  e;
    logic [47:0] m;
    logic        o, u, z;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;

  mult_norm_ctrl #(.EXP_W(8), .MANT_W(23)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_exp(in_exp), .in_mant(in_mant), .out_valid(out_valid), .out_ready(out_ready),
    .out_exp(out_exp), .out_mant(out_mant), .ovf(ovf), .unf(unf), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  // monitor: each delivered result (valid & ready) is compared against the oldest expectation
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_output", 64'(out_valid), 64'd0);
      else begin
        exp_t x;
        x = q.pop_front();
        chk("out_exp", 64'(out_exp), 64'(x.e));
        chk("out_mant", 64'(out_mant), 64'(x.m));
        chk("ovf", 64'(ovf), 64'(x.o));
        chk("unf", 64'(unf), 64'(x.u));
        chk("zero", 64'(zero), 64'(x.z));
      end
    end
  end

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) chk("out_valid_timeout", 64'(out_valid), 64'd1);
  endtask

  task automatic start(input logic [7:0] e, input logic [47:0] m);
    int n;
    n = 0;
    in_exp = e;
    in_mant = m;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic op(input logic [7:0] e, input logic [47:0] m, input logic [7:0] ee,
                    input logic [47:0] me, input logic o, input logic u, input logic z, input int le);
    int lat;
    q.push_back('{ee, me, o, u, z});
    start(e, m);
    wait_out(lat);
    chk("latency", 64'(lat), 64'(le));
    @(posedge clk); #1;
    chk("idle_after_handshake", 64'({busy, in_ready, out_valid}), 64'b010);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]  se;
    logic [47:0] sm;
    int lat;
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_outs", 64'({out_valid, busy, ovf, unf, zero}), 64'd0);
    chk("rst_data", 64'({out_exp, out_mant}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    op(8'd100, 48'h8000_0000_0000, 8'd101, 48'h4000_0000_0000, 0, 0, 0, 2);
    op(8'd100, 48'h0800_0000_0000, 8'd97,  48'h4000_0000_0000, 0, 0, 0, 5);
    op(8'd3,   48'h0000_0000_0001, 8'd0,   48'h0000_0000_0008, 0, 1, 0, 5);
    op(8'd77,  48'h0000_0000_0000, 8'd0,   48'h0000_0000_0000, 0, 0, 1, 2);
    op(8'd254, 48'hC000_0000_0000, 8'd255, 48'h6000_0000_0000, 1, 0, 0, 2);
    op(8'd255, 48'h8000_0000_0000, 8'd255, 48'h4000_0000_0000, 1, 0, 0, 2);
    op(8'd50,  48'h4000_0000_0001, 8'd50,  48'h4000_0000_0001, 0, 0, 0, 2);
    op(8'd0,   48'h2000_0000_0000, 8'd0,   48'h2000_0000_0000, 0, 1, 0, 2);

    // backpressure: result held, new request ignored until the cycle after the handshake
    out_ready = 1'b0;
    q.push_back('{8'd11, 48'h4000_0000_0000, 1'b0, 1'b0, 1'b0});
    start(8'd10, 48'h8000_0000_0001);
    wait_out(lat);
    chk("bp_latency", 64'(lat), 64'd2);
    se = out_exp;
    sm = out_mant;
    q.push_back('{8'd0, 48'h0, 1'b0, 1'b0, 1'b1});
    in_exp = 8'd5;
    in_mant = '0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_hold", 64'({out_valid, in_ready, busy}), 64'b101);
      chk("bp_stable", 64'({out_exp, out_mant}), 64'({se, sm}));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_not_yet_accepted", 64'({busy, in_ready}), 64'b01);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_accepted", 64'({busy, in_ready}), 64'b10);
    wait_out(lat);
    chk("bp2_latency", 64'(lat), 64'd2);
    @(posedge clk); #1;

    // reset in the middle of a left-shift normalisation
    in_exp = 8'd100;
    in_mant = 48'h0800_0000_0000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_rst_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_state", 64'({out_valid, busy, in_ready}), 64'b001);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_valid", 64'(out_valid), 64'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    op(8'd100, 48'h0800_0000_0000, 8'd97, 48'h4000_0000_0000, 0, 0, 0, 5);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
